// File: rtl/router_pkg.sv
// Package shared by the router blocks (input FIFO, arbiter, LBDR, crossbar).
// Holds the default flit width, output port indices and the one-hot
// read-enable vector type used between the arbiters and the input FIFOs.
package router_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  // Output port indices; bit order of every per-port vector.
  localparam int PORT_N    = 0;
  localparam int PORT_E    = 1;
  localparam int PORT_W    = 2;
  localparam int PORT_S    = 3;
  localparam int PORT_L    = 4;
  localparam int NUM_PORTS = 5;

  typedef logic [NUM_PORTS-1:0] read_en_t;

  // True when more than one bit of the vector is set.
  function automatic logic multi_hot(input read_en_t v);
    return |(v & (v - read_en_t'(1)));
  endfunction

endpackage

// File: rtl/fifo_cts_handshake.sv
// Upstream side of the RTS/CTS handshake for a router input FIFO.
// A write is taken when the neighbour requests (drts), our previous CTS pulse
// has ended and the FIFO has room. CTS is then raised for exactly one cycle,
// which also masks a request the neighbour is still holding during that cycle.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   drts      upstream request-to-send
//   full      FIFO full flag (registered-derived)
//   wr_en     write strobe for the storage array and write pointer
//   cts       registered clear-to-send pulse back to the neighbour
module fifo_cts_handshake (
  input  logic clk,
  input  logic rst,
  input  logic drts,
  input  logic full,
  output logic wr_en,
  output logic cts
);

  // Every term is registered or a primary input from a register upstream,
  // so there is no combinational loop through the neighbour.
  assign wr_en = drts & ~cts & ~full;

  always_ff @(posedge clk) begin
    if (rst) cts <= 1'b0;
    else     cts <= wr_en;
  end

endmodule

// File: rtl/router_input_fifo.sv
// Input buffer of one router port.
// Flits arrive over the RTS/CTS handshake, are stored in a DEPTH-entry circular
// buffer, and the head flit is presented combinationally to routing and the
// output arbiters, which pop it with a one-hot read enable.
// Handshake (valid/ready): a flit on RX is offered while DRTS=1 and is
// transferred on the clock edge where DRTS=1, CTS=0 and full=0; CTS=1 in the
// following cycle acknowledges it and the neighbour drops DRTS on that edge.
// A pop happens on any edge where read_en is non-zero and empty=0.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   RX         incoming flit, valid while DRTS=1
//   DRTS       upstream request-to-send
//   read_en    pop request, one bit per output port (N,E,W,S,L)
//   CTS        clear-to-send pulse to upstream
//   Data_out   head flit, meaningless while empty=1
//   empty      no flits stored
//   full       DEPTH flits stored
//   err_multi  sticky: more than one read_en bit seen while not empty
module router_input_fifo
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  input  read_en_t              read_en,
  output logic                  CTS,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  err_multi
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  wr_en;
  logic                  pop;

  fifo_cts_handshake u_handshake (
    .clk   (clk),
    .rst   (rst),
    .drts  (DRTS),
    .full  (full),
    .wr_en (wr_en),
    .cts   (CTS)
  );

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop      = (|read_en) & ~empty;
  assign Data_out = mem[rd_ptr];

  // Storage is deliberately not reset; reset only suppresses the write.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= RX;
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap without a compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_multi <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pop && multi_hot(read_en)) err_multi <= 1'b1;
    end
  end

endmodule
